trigger_out_collector: RTL
==========================

// Module: trigger_out_collector
// PURPOSE
//  FPGA-to-host event path; counterpart of the host-to-FPGA trigger inputs. Captures one-cycle event
//  pulses from sys_clk logic into sticky pending bits and produces an atomic snapshot on host request.
//  Holds the snapshot until the host acknowledges it. Keeps per-bit overrun flags and a running event
//  total. Outputs are exposed through TriggerOut and WireOut endpoints; rd_req and snap_ack arrive via TriggerIn.
// PARAMETERS
//  N_EVENTS  16      number of event bits (1..32)
//  CNT_W     16      width of event_count
//  TIMEOUT   1024    max sys_clk cycles in PRESENT without snap_ack (>=2)
// PORTS
//  sys_clk      in   1         single clock, all logic rising-edge
//  reset        in   1         synchronous, active-high
//  ev_in        in   N_EVENTS  event pulses, any bits, any cycle
//  rd_req       in   1         host snapshot request, 1-cycle pulse
//  snap_ack     in   1         host done reading snapshot, 1-cycle pulse
//  clr_status   in   1         clears overrun, rd_drop, ack_timeout
//  snap_data    out  N_EVENTS  captured event bits, stable while snap_valid
//  snap_valid   out  1         high from capture until ack/timeout
//  pending      out  N_EVENTS  live pending bits
//  overrun      out  N_EVENTS  sticky: event hit an already-pending bit
//  rd_drop      out  1         sticky: rd_req arrived while not IDLE
//  ack_timeout  out  1         sticky: PRESENT exited by timeout
//  event_count  out  CNT_W     total accepted event bits, wraps mod 2^CNT_W
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; timeout counter 0. reset overrides all other inputs.
//  - States: IDLE, PRESENT. All outputs registered.
//  - IDLE & rd_req at cycle T:
//    - at T+1: snap_data=pending|ev_in(T); pending=0; snap_valid=1; state=PRESENT; tmo=0.
//    - An event in cycle T lands in the snapshot, not in pending. It does not cause an overrun.
//  - Outside a capture cycle: pending[i] <= pending[i] | ev_in[i].
//    - ev_in[i] & pending[i] sets overrun[i].
//  - PRESENT: snap_data frozen; pending keeps accumulating; tmo increments each cycle.
//    - snap_ack: next cycle state=IDLE, snap_valid=0. snap_data keeps its last value.
//    - tmo==TIMEOUT-1 with no ack: next cycle state=IDLE, snap_valid=0, ack_timeout=1.
//    - Ack and timeout in the same cycle: the ack wins; ack_timeout is not set.
//    - rd_req in PRESENT is ignored and sets rd_drop, including when it coincides with snap_ack.
//    - A new capture needs a later rd_req in IDLE.
//  - snap_ack in IDLE: ignored, no flag.
//  - clr_status: clears the sticky flags next cycle. A set in the same cycle wins over the clear.
//  - event_count: += popcount(ev_in) every cycle, including capture cycles.
//    - Popcount width is $clog2(N_EVENTS+1), zero-extended to CNT_W. Wraps silently.
//  - Latency: rd_req to snap_valid = 1 cycle. snap_ack to snap_valid low = 1 cycle.
// STRUCTURE
//  - Shared package ok_ep_pkg holds:
//    - state encoding localparams TOC_IDLE=1'b0, TOC_PRESENT=1'b1
//    - the $clog2-based popcount width helper
//  - One sub-module: event_popcount #(N) (combinational adder tree, ev_in -> count).
//  - The top contains the FSM, pending/overrun registers, timeout counter, and accumulator.
// TESTING
//  1. Reset, then ev_in=16'h0005 for 1 cycle, rd_req 2 cycles later:
//     pending=0005, then snap_data=0005, snap_valid=1, pending=0, event_count=2.
//  2. ev_in=16'h0001 and rd_req in the same IDLE cycle:
//     snap_data=0001, pending=0, overrun=0.
//  3. ev_in bit3 twice, 4 cycles apart, no rd_req:
//     overrun=0008; clr_status then clears it to 0. Repeat with clr_status plus a new overrun
//     in the same cycle: overrun stays 0008.
//  4. rd_req, then rd_req again in PRESENT:
//     rd_drop=1, snap_data unchanged. snap_ack: snap_valid=0 next cycle.
//  5. TIMEOUT=8, rd_req with no ack:
//     snap_valid high for exactly 8 cycles, then 0, ack_timeout=1. snap_ack on the last cycle:
//     ack_timeout stays 0.
//  6. CNT_W=4, ev_in=16'hFFFF for 1 cycle, then 16'h0003:
//     event_count 0 -> 0 (16 mod 16) -> 2. Reset asserted during PRESENT: all outputs 0 next cycle.

Source files
------------

// File: rtl/ok_ep_pkg.sv
// Shared definitions for the trigger-out event path.
//  - TOC_* : state encodings of the trigger_out_collector FSM
//  - toc_state_t : FSM state type built on those encodings
//  - popcount_width() : bits needed to hold a popcount of n inputs
package ok_ep_pkg;

   localparam logic TOC_IDLE    = 1'b0;
   localparam logic TOC_PRESENT = 1'b1;

   typedef enum logic {
      ST_IDLE    = TOC_IDLE,
      ST_PRESENT = TOC_PRESENT
   } toc_state_t;

   function automatic int popcount_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/event_popcount.sv
// Combinational population count of an event vector.
// Ports:
//  i_bits   in  N  event bits
//  o_count  out W  number of set bits in i_bits
module event_popcount
   import ok_ep_pkg::*;
#(
   parameter int N = 16,
   parameter int W = popcount_width(N)
) (
   input  logic [N-1:0] i_bits,
   output logic [W-1:0] o_count
);

   // Written as a linear sum; synthesis rebalances it into an adder tree.
   always_comb begin
      o_count = '0;
      for (int i = 0; i < N; i++) begin
         o_count = o_count + W'(i_bits[i]);
      end
   end

endmodule

// File: rtl/trigger_out_collector.sv
// FPGA-to-host event collector. One-cycle event pulses are folded into sticky
// pending bits; a host rd_req moves pending (plus same-cycle events) into a
// snapshot that is held until snap_ack or until the timeout expires.
// Ports:
//  i_sys_clk       in   1         clock, rising edge
//  i_reset         in   1         synchronous, active-high
//  i_ev_in         in   N_EVENTS  event pulses
//  i_rd_req        in   1         snapshot request pulse
//  i_snap_ack      in   1         snapshot consumed pulse
//  i_clr_status    in   1         clear overrun / rd_drop / ack_timeout
//  o_snap_data     out  N_EVENTS  captured events, stable while o_snap_valid
//  o_snap_valid    out  1         snapshot being presented
//  o_pending       out  N_EVENTS  live pending bits
//  o_overrun       out  N_EVENTS  sticky: event on an already-pending bit
//  o_rd_drop       out  1         sticky: rd_req seen while presenting
//  o_ack_timeout   out  1         sticky: presentation ended by timeout
//  o_event_count   out  CNT_W     running total of accepted event bits
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | collecting events, waiting for rd_req
// PRESENT  | snapshot held for host, waiting for ack/timeout
module trigger_out_collector
   import ok_ep_pkg::*;
#(
   parameter int N_EVENTS = 16,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1024
) (
   input  logic                i_sys_clk,
   input  logic                i_reset,
   input  logic [N_EVENTS-1:0] i_ev_in,
   input  logic                i_rd_req,
   input  logic                i_snap_ack,
   input  logic                i_clr_status,
   output logic [N_EVENTS-1:0] o_snap_data,
   output logic                o_snap_valid,
   output logic [N_EVENTS-1:0] o_pending,
   output logic [N_EVENTS-1:0] o_overrun,
   output logic                o_rd_drop,
   output logic                o_ack_timeout,
   output logic [CNT_W-1:0]    o_event_count
);

   localparam int POP_W = popcount_width(N_EVENTS);
   localparam int TMO_W = $clog2(TIMEOUT);

   toc_state_t          r_state;
   toc_state_t          w_state_nxt;
   logic [N_EVENTS-1:0] r_snap_data;
   logic                r_snap_valid;
   logic [N_EVENTS-1:0] r_pending;
   logic [N_EVENTS-1:0] r_overrun;
   logic                r_rd_drop;
   logic                r_ack_timeout;
   logic [CNT_W-1:0]    r_event_count;
   logic [TMO_W-1:0]    r_tmo;

   logic                w_capture;
   logic                w_tmo_exit;
   logic                w_drop;
   logic [POP_W-1:0]    w_pop;
   logic [N_EVENTS-1:0] w_ovr_set;

   event_popcount #(
      .N (N_EVENTS),
      .W (POP_W)
   ) u_popcount (
      .i_bits  (i_ev_in),
      .o_count (w_pop)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_tmo_exit  = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_rd_req) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            w_drop = i_rd_req;
            // Ack has priority over an expiring timeout.
            if (i_snap_ack) begin
               w_state_nxt = ST_IDLE;
            end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
               w_tmo_exit  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Events in the capture cycle go straight into the snapshot, so they
   // never collide with pending and cannot raise an overrun.
   assign w_ovr_set = w_capture ? '0 : (i_ev_in & r_pending);

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_snap_data   <= '0;
         r_snap_valid  <= 1'b0;
         r_pending     <= '0;
         r_overrun     <= '0;
         r_rd_drop     <= 1'b0;
         r_ack_timeout <= 1'b0;
         r_event_count <= '0;
         r_tmo         <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_snap_valid <= (w_state_nxt == ST_PRESENT);

         if (w_capture) begin
            r_snap_data <= r_pending | i_ev_in;
            r_pending   <= '0;
            r_tmo       <= '0;
         end else begin
            r_pending <= r_pending | i_ev_in;
            if (r_state == ST_PRESENT) begin
               r_tmo <= r_tmo + TMO_W'(1);
            end
         end

         // Sticky flags: a set in the same cycle beats the clear.
         r_overrun     <= (i_clr_status ? '0 : r_overrun) | w_ovr_set;
         r_rd_drop     <= (i_clr_status ? 1'b0 : r_rd_drop) | w_drop;
         r_ack_timeout <= (i_clr_status ? 1'b0 : r_ack_timeout) | w_tmo_exit;

         r_event_count <= r_event_count + CNT_W'(w_pop);
      end
   end

   assign o_snap_data   = r_snap_data;
   assign o_snap_valid  = r_snap_valid;
   assign o_pending     = r_pending;
   assign o_overrun     = r_overrun;
   assign o_rd_drop     = r_rd_drop;
   assign o_ack_timeout = r_ack_timeout;
   assign o_event_count = r_event_count;

endmodule
